vc_demux: RTL and testbench
===========================

// Module: vc_demux
// PURPOSE
// - Output-side counterpart of the VC plane mux: takes flits leaving the crossbar on each output
//   port and steers them into the VC plane named by VCPlaneSelector.
// - Buffers each (VC, output) lane in a 2-entry elastic FIFO and tracks packet framing per lane.
// - Reports per-lane packet-in-progress status and a sticky framing error.
// PARAMETERS
// - VC          4   number of virtual-channel planes
// - OUTPUTS     4   crossbar output ports
// - DATA_WIDTH  32  flit width; bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the flit type
// PORTS
// - clk                 in   1                    rising-edge clock, single clock domain
// - rst_n               in   1                    asynchronous, active-low reset
// - VCPlaneSelector     in   VC+1                 plane carried by the switch this cycle
// - data_out_switch     in   OUTPUTS*DATA_WIDTH   crossbar output flits
// - valid_out_switch    in   OUTPUTS              crossbar output valid
// - ready_out_switch    out  OUTPUTS              accept, per output
// - data_in_portVC      out  VC*OUTPUTS*DATA_WIDTH  flit at each lane FIFO head
// - valid_in_portVC     out  VC*OUTPUTS           lane FIFO non-empty
// - ready_in_portVC     in   VC*OUTPUTS           downstream accept, per lane
// - packetActiveVC      out  VC*OUTPUTS           lane has received a head flit but not its tail
// - framingError        out  1                    sticky framing violation
// BEHAVIOUR
// - Reset: all FIFOs empty; valid_in_portVC=0; packetActiveVC=0; framingError=0; ready_out_switch=0.
// - Selector range: sel = VCPlaneSelector. If sel >= VC, ready_out_switch=0 and nothing is written.
// - Ready: ready_out_switch[o] = !full[sel][o]. It is a function of registered FIFO counts only,
//   with no combinational path from ready_in_portVC.
// - Write: on valid_out_switch[o] && ready_out_switch[o], the flit is pushed into lane [sel][o].
//   All other lanes are untouched.
// - Read: lane [v][o] pops when valid_in_portVC[v][o] && ready_in_portVC[v][o].
// - Latency: data_in_portVC is the FIFO head register, so a flit written at edge N is visible
//   after edge N. There is no combinational switch-to-port bypass.
// - FIFO, 2 entries per lane:
//   - Count is 0..2. A simultaneous push and pop leaves the count unchanged.
//   - A push is possible when full only if a pop happens in the same cycle; ready stays low while
//     full, so this case does not arise at the switch side.
//   - Sustained push and pop on one lane gives 1 flit/cycle.
// - Flit types in data[DATA_WIDTH-1 -: 2]: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE.
// - Per-lane framing FSM, advanced on the write handshake:
//   - IDLE: HEAD -> OPEN; SINGLE -> IDLE; BODY or TAIL -> IDLE and set framingError.
//   - OPEN: BODY -> OPEN; TAIL -> IDLE; HEAD or SINGLE -> OPEN and set framingError.
//   - Flits that violate framing are still stored and forwarded.
//   - packetActiveVC[v][o] = (state == OPEN), registered.
// - framingError clears only on reset.
// - Reset mid-packet: FIFO contents are discarded, FSMs return to IDLE, and outputs take their
//   reset values immediately (asynchronous).
// - A selector change between cycles is legal; each lane keeps its own FSM state.
// STRUCTURE
// - Shared package noc_pkg holds:
//   - typedef flit_type_t {BODY=2'b00, TAIL=2'b01, HEAD=2'b10, SINGLE=2'b11}
//   - localparam FLIT_TYPE_W = 2
//   - function flit_type(data)
// - Sub-module vc_demux_fifo2 is the 2-entry FIFO plus framing FSM, instantiated VC*OUTPUTS times
//   with generate.
// - The top level contains only selector decode and the ready mux.
// TESTING
// - Reset release, no traffic -> ready_out_switch=4'hF; valid_in_portVC=0; packetActiveVC=0;
//   framingError=0.
// - sel=2, out1 sends HEAD(0x8000_0001), BODY, TAIL over 3 cycles with ready_in_portVC all 1 ->
//   lane[2][1] shows the same 3 flits one cycle later; packetActiveVC[2][1] is 1 after HEAD and
//   0 after TAIL; no other lane goes valid.
// - ready_in_portVC[0][0]=0, sel=0, out0 streams 3 flits -> first 2 are accepted, then
//   ready_out_switch[0]=0. Raise ready -> in-order drain and ready returns high the cycle after
//   the first pop.
// - sel=4 (== VC) with valid_out_switch=4'hF -> ready_out_switch=0; no lane is written.
// - TAIL on an IDLE lane [1][3] -> framingError=1, the flit is still delivered, and the error
//   stays set through further valid traffic.
// - rst_n pulsed low mid-packet with lane[3][2] holding 2 flits -> asynchronous clear: valid=0,
//   packetActive=0. After release, a new HEAD is accepted with no error.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types: flit type encoding, per-lane framing state and a flit-type decode helper.
package noc_pkg;

    localparam int unsigned FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        BODY   = 2'b00,
        TAIL   = 2'b01,
        HEAD   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } lane_state_t;

    // Caller passes the top FLIT_TYPE_W bits of the flit so the helper stays width-agnostic.
    function automatic flit_type_t flit_type(input logic [FLIT_TYPE_W-1:0] typeBits);
        return flit_type_t'(typeBits);
    endfunction

endpackage

// File: rtl/vc_demux_if.sv
// Switch-side and port-side bundle of the VC plane demux.
interface vc_demux_if #(
    parameter int unsigned VC         = 4,
    parameter int unsigned OUTPUTS    = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned SEL_W = VC + 1;

    logic [SEL_W-1:0]                 VCPlaneSelector;
    logic [OUTPUTS*DATA_WIDTH-1:0]    data_out_switch;
    logic [OUTPUTS-1:0]               valid_out_switch;
    logic [OUTPUTS-1:0]               ready_out_switch;
    logic [VC*OUTPUTS*DATA_WIDTH-1:0] data_in_portVC;
    logic [VC*OUTPUTS-1:0]            valid_in_portVC;
    logic [VC*OUTPUTS-1:0]            ready_in_portVC;
    logic [VC*OUTPUTS-1:0]            packetActiveVC;
    logic                             framingError;

    modport master (
        output VCPlaneSelector, data_out_switch, valid_out_switch, ready_in_portVC,
        input  ready_out_switch, data_in_portVC, valid_in_portVC, packetActiveVC, framingError
    );

    modport slave (
        input  VCPlaneSelector, data_out_switch, valid_out_switch, ready_in_portVC,
        output ready_out_switch, data_in_portVC, valid_in_portVC, packetActiveVC, framingError
    );

endinterface

// File: rtl/vc_demux_fifo2.sv
// One (VC, output) lane: 2-entry elastic FIFO with head register output, plus packet framing tracker.
module vc_demux_fifo2
    import noc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  popReady,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  packetActive,
    output logic                  frameErr
);

    logic [DATA_WIDTH-1:0] headQ;
    logic [DATA_WIDTH-1:0] tailQ;
    logic [1:0]            countQ;
    lane_state_t           stateQ;
    logic                  errQ;
    logic                  popC;
    flit_type_t            flitTypeC;

    assign popC      = (countQ != 2'd0) && popReady;
    assign flitTypeC = flit_type(din[DATA_WIDTH-1 -: FLIT_TYPE_W]);

    // headQ always holds the oldest entry so the port sees it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= 2'd0;
        end else begin
            unique case ({push, popC})
                2'b10: begin
                    if (countQ == 2'd0) headQ <= din;
                    else                tailQ <= din;
                    countQ <= countQ + 2'd1;
                end
                2'b01: begin
                    headQ  <= tailQ;
                    countQ <= countQ - 2'd1;
                end
                2'b11: begin
                    if (countQ == 2'd1) begin
                        headQ <= din;
                    end else begin
                        headQ <= tailQ;
                        tailQ <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    // Framing tracker advances on every accepted write; violating flits are still stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
            errQ   <= 1'b0;
        end else if (push) begin
            unique case (stateQ)
                IDLE: begin
                    unique case (flitTypeC)
                        HEAD:    stateQ <= OPEN;
                        SINGLE:  stateQ <= IDLE;
                        default: errQ   <= 1'b1;
                    endcase
                end
                OPEN: begin
                    unique case (flitTypeC)
                        TAIL:    stateQ <= IDLE;
                        BODY:    stateQ <= OPEN;
                        default: errQ   <= 1'b1;
                    endcase
                end
                default: stateQ <= IDLE;
            endcase
        end
    end

    assign dout         = headQ;
    assign valid        = (countQ != 2'd0);
    assign full         = (countQ == 2'd2);
    assign packetActive = (stateQ == OPEN);
    assign frameErr     = errQ;

endmodule

// File: rtl/vc_demux.sv
// Steers crossbar output flits into the VC plane named by VCPlaneSelector, one FIFO lane per (VC, output).
module vc_demux
    import noc_pkg::*;
#(
    parameter int unsigned VC         = 4,
    parameter int unsigned OUTPUTS    = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    vc_demux_if.slave   bus
);

    localparam int unsigned SEL_W = VC + 1;
    localparam int unsigned LANES = VC * OUTPUTS;

    logic [VC-1:0]      selHotC;
    logic               selValidC;
    logic [OUTPUTS-1:0] blockedC;
    logic [OUTPUTS-1:0] readyC;
    logic [LANES-1:0]   laneWriteC;
    logic [LANES-1:0]   laneFull;
    logic [LANES-1:0]   laneErr;
    logic               runningQ;

    // Holds ready low while in reset and until the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) runningQ <= 1'b0;
        else        runningQ <= 1'b1;
    end

    // Selector decode; out-of-range values select no plane.
    always_comb begin
        selHotC = '0;
        for (int unsigned v = 0; v < VC; v++) begin
            if (bus.VCPlaneSelector == SEL_W'(v)) selHotC[v] = 1'b1;
        end
        selValidC = |selHotC;
    end

    // Ready depends only on registered lane fullness of the selected plane.
    always_comb begin
        blockedC   = '0;
        laneWriteC = '0;
        for (int unsigned v = 0; v < VC; v++) begin
            for (int unsigned o = 0; o < OUTPUTS; o++) begin
                if (selHotC[v] && laneFull[v*OUTPUTS + o]) blockedC[o] = 1'b1;
            end
        end
        readyC = {OUTPUTS{runningQ & selValidC}} & ~blockedC;
        for (int unsigned v = 0; v < VC; v++) begin
            for (int unsigned o = 0; o < OUTPUTS; o++) begin
                laneWriteC[v*OUTPUTS + o] = selHotC[v] & bus.valid_out_switch[o] & readyC[o];
            end
        end
    end

    assign bus.ready_out_switch = readyC;
    assign bus.framingError     = |laneErr;

    for (genvar v = 0; v < VC; v++) begin : gVc
        for (genvar o = 0; o < OUTPUTS; o++) begin : gOut
            localparam int unsigned LANE = v*OUTPUTS + o;
            vc_demux_fifo2 #(
                .DATA_WIDTH(DATA_WIDTH)
            ) uLane (
                .clk          (clk),
                .rst_n        (rst_n),
                .push         (laneWriteC[LANE]),
                .din          (bus.data_out_switch[o*DATA_WIDTH +: DATA_WIDTH]),
                .popReady     (bus.ready_in_portVC[LANE]),
                .dout         (bus.data_in_portVC[LANE*DATA_WIDTH +: DATA_WIDTH]),
                .valid        (bus.valid_in_portVC[LANE]),
                .full         (laneFull[LANE]),
                .packetActive (bus.packetActiveVC[LANE]),
                .frameErr     (laneErr[LANE])
            );
        end
    end

endmodule

// File: tb/tb_vc_demux.sv
// Directed bench for vc_demux: reset, packet steering, backpressure, bad selector, framing, async reset.
module tb_vc_demux;

    localparam int unsigned VC  = 4;
    localparam int unsigned OUT = 4;
    localparam int unsigned DW  = 32;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nFails;

    vc_demux_if #(.VC(VC), .OUTPUTS(OUT), .DATA_WIDTH(DW)) bus ();

    vc_demux #(.VC(VC), .OUTPUTS(OUT), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [DW-1:0] laneDat [VC*OUT];
    always_comb begin
        for (int i = 0; i < VC*OUT; i++) laneDat[i] = bus.data_in_portVC[i*DW +: DW];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendFlit(input int o, input logic [DW-1:0] d);
        bus.data_out_switch             = '0;
        bus.data_out_switch[o*DW +: DW] = d;
        bus.valid_out_switch            = 4'(1 << o);
    endtask

    task automatic test_reset();
        rst_n                = 1'b0;
        bus.VCPlaneSelector  = 5'd0;
        bus.data_out_switch  = '0;
        bus.valid_out_switch = '0;
        bus.ready_in_portVC  = '1;
        #3;
        nChecks++;
        if (bus.ready_out_switch !== 4'h0) begin
            nFails++; $display("FAIL reset_ready_in_reset got %h want 0", bus.ready_out_switch);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        tick();
        nChecks++;
        if (bus.ready_out_switch !== 4'hF) begin
            nFails++; $display("FAIL reset_ready got %h want f", bus.ready_out_switch);
        end
        nChecks++;
        if (bus.valid_in_portVC !== 16'h0) begin
            nFails++; $display("FAIL reset_valid got %h want 0", bus.valid_in_portVC);
        end
        nChecks++;
        if (bus.packetActiveVC !== 16'h0) begin
            nFails++; $display("FAIL reset_active got %h want 0", bus.packetActiveVC);
        end
        nChecks++;
        if (bus.framingError !== 1'b0) begin
            nFails++; $display("FAIL reset_ferr got %b want 0", bus.framingError);
        end
    endtask

    task automatic test_packet();
        logic [DW-1:0] flits [3];
        logic [15:0]   expAct [3];
        flits  = '{32'h8000_0001, 32'h0000_0002, 32'h4000_0003};
        expAct = '{16'h0200, 16'h0200, 16'h0000};
        bus.VCPlaneSelector = 5'd2;
        bus.ready_in_portVC = '1;
        for (int i = 0; i < 3; i++) begin
            sendFlit(1, flits[i]);
            tick();
            nChecks++;
            if (bus.valid_in_portVC !== 16'h0200) begin
                nFails++; $display("FAIL pkt_valid[%0d] got %h want 0200", i, bus.valid_in_portVC);
            end
            nChecks++;
            if (laneDat[9] !== flits[i]) begin
                nFails++; $display("FAIL pkt_data[%0d] got %h want %h", i, laneDat[9], flits[i]);
            end
            nChecks++;
            if (bus.packetActiveVC !== expAct[i]) begin
                nFails++; $display("FAIL pkt_active[%0d] got %h want %h", i, bus.packetActiveVC, expAct[i]);
            end
        end
        bus.valid_out_switch = '0;
        tick();
        nChecks++;
        if (bus.valid_in_portVC !== 16'h0) begin
            nFails++; $display("FAIL pkt_drain got %h want 0", bus.valid_in_portVC);
        end
        nChecks++;
        if (bus.framingError !== 1'b0) begin
            nFails++; $display("FAIL pkt_ferr got %b want 0", bus.framingError);
        end
    endtask

    task automatic test_back_to_back();
        // step: 0 push F1, 1 push F2, 2 offer F3 blocked, 3 raise ready, 4 F3 accepted with pop
        logic [DW-1:0] offer   [5];
        logic [15:0]   rdyIn   [5];
        logic [3:0]    expRdy  [5];
        logic [DW-1:0] expHead [5];
        offer   = '{32'hC000_000A, 32'hC000_000B, 32'hC000_000C, 32'hC000_000C, 32'hC000_000C};
        rdyIn   = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF};
        expRdy  = '{4'hF, 4'hE, 4'hE, 4'hF, 4'hF};
        expHead = '{32'hC000_000A, 32'hC000_000A, 32'hC000_000A, 32'hC000_000B, 32'hC000_000C};
        bus.VCPlaneSelector = 5'd0;
        for (int i = 0; i < 5; i++) begin
            bus.ready_in_portVC = rdyIn[i];
            sendFlit(0, offer[i]);
            tick();
            nChecks++;
            if (bus.ready_out_switch !== expRdy[i]) begin
                nFails++; $display("FAIL bp_ready[%0d] got %h want %h", i, bus.ready_out_switch, expRdy[i]);
            end
            nChecks++;
            if (bus.valid_in_portVC !== 16'h0001 || laneDat[0] !== expHead[i]) begin
                nFails++; $display("FAIL bp_head[%0d] got v=%h d=%h want v=0001 d=%h",
                                   i, bus.valid_in_portVC, laneDat[0], expHead[i]);
            end
        end
        bus.valid_out_switch = '0;
        tick();
        nChecks++;
        if (bus.valid_in_portVC !== 16'h0) begin
            nFails++; $display("FAIL bp_empty got %h want 0", bus.valid_in_portVC);
        end
    endtask

    task automatic test_bad_sel();
        bus.ready_in_portVC  = '1;
        bus.VCPlaneSelector  = 5'd4;
        bus.data_out_switch  = {4{32'hC000_00EE}};
        bus.valid_out_switch = 4'hF;
        #1;
        nChecks++;
        if (bus.ready_out_switch !== 4'h0) begin
            nFails++; $display("FAIL badsel_ready got %h want 0", bus.ready_out_switch);
        end
        tick();
        nChecks++;
        if (bus.valid_in_portVC !== 16'h0) begin
            nFails++; $display("FAIL badsel_write got %h want 0", bus.valid_in_portVC);
        end
        bus.valid_out_switch = '0;
        tick();
    endtask

    task automatic test_framing();
        bus.VCPlaneSelector = 5'd1;
        sendFlit(3, 32'h4000_0055);
        tick();
        nChecks++;
        if (bus.framingError !== 1'b1) begin
            nFails++; $display("FAIL ferr_set got %b want 1", bus.framingError);
        end
        nChecks++;
        if (bus.valid_in_portVC !== 16'h0080 || laneDat[7] !== 32'h4000_0055) begin
            nFails++; $display("FAIL ferr_deliver got v=%h d=%h want v=0080 d=40000055",
                               bus.valid_in_portVC, laneDat[7]);
        end
        nChecks++;
        if (bus.packetActiveVC !== 16'h0) begin
            nFails++; $display("FAIL ferr_active got %h want 0", bus.packetActiveVC);
        end
        sendFlit(3, 32'hC000_0066);
        tick();
        nChecks++;
        if (bus.framingError !== 1'b1 || laneDat[7] !== 32'hC000_0066) begin
            nFails++; $display("FAIL ferr_sticky got e=%b d=%h want e=1 d=c0000066",
                               bus.framingError, laneDat[7]);
        end
        bus.valid_out_switch = '0;
        tick();
        nChecks++;
        if (bus.framingError !== 1'b1 || bus.valid_in_portVC !== 16'h0) begin
            nFails++; $display("FAIL ferr_idle got e=%b v=%h want e=1 v=0",
                               bus.framingError, bus.valid_in_portVC);
        end
    endtask

    task automatic test_reset_mid_packet();
        bus.ready_in_portVC = 16'hBFFF;
        bus.VCPlaneSelector = 5'd3;
        sendFlit(2, 32'h8000_0100);
        tick();
        sendFlit(2, 32'h0000_0101);
        tick();
        bus.valid_out_switch = '0;
        nChecks++;
        if (bus.valid_in_portVC !== 16'h4000 || bus.packetActiveVC !== 16'h4000
            || bus.ready_out_switch !== 4'hB) begin
            nFails++; $display("FAIL rmid_pre got v=%h a=%h r=%h want v=4000 a=4000 r=b",
                               bus.valid_in_portVC, bus.packetActiveVC, bus.ready_out_switch);
        end
        #2 rst_n = 1'b0;
        #1;
        nChecks++;
        if (bus.valid_in_portVC !== 16'h0 || bus.packetActiveVC !== 16'h0) begin
            nFails++; $display("FAIL rmid_clear got v=%h a=%h want 0 0",
                               bus.valid_in_portVC, bus.packetActiveVC);
        end
        nChecks++;
        if (bus.framingError !== 1'b0 || bus.ready_out_switch !== 4'h0) begin
            nFails++; $display("FAIL rmid_outs got e=%b r=%h want e=0 r=0",
                               bus.framingError, bus.ready_out_switch);
        end
        #2 rst_n = 1'b1;
        bus.ready_in_portVC = '1;
        tick();
        sendFlit(2, 32'h8000_0200);
        tick();
        nChecks++;
        if (bus.valid_in_portVC !== 16'h4000 || laneDat[14] !== 32'h8000_0200) begin
            nFails++; $display("FAIL rmid_head got v=%h d=%h want v=4000 d=80000200",
                               bus.valid_in_portVC, laneDat[14]);
        end
        nChecks++;
        if (bus.packetActiveVC !== 16'h4000 || bus.framingError !== 1'b0) begin
            nFails++; $display("FAIL rmid_state got a=%h e=%b want a=4000 e=0",
                               bus.packetActiveVC, bus.framingError);
        end
        sendFlit(2, 32'h4000_0201);
        tick();
        bus.valid_out_switch = '0;
        nChecks++;
        if (bus.packetActiveVC !== 16'h0 || bus.framingError !== 1'b0) begin
            nFails++; $display("FAIL rmid_tail got a=%h e=%b want a=0 e=0",
                               bus.packetActiveVC, bus.framingError);
        end
        tick();
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        test_reset();
        test_packet();
        test_back_to_back();
        test_bad_sel();
        test_framing();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
